// File: rtl/dse_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dse_pkg
// Purpose : Shared types and constants for the DSE stream endpoint: record
//           tags, controller state encoding, default reset-vector targets
//           and a saturating 32-bit adder.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package dse_pkg;

  // Record tags carried in the upper MAGIC_W bits of every output record.
  typedef enum logic [7:0] {
    TAG_EMULATE = 8'd1,
    TAG_DEG     = 8'd2,
    TAG_DEGDONE = 8'd3,
    TAG_FINISH  = 8'd4
  } tag_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RECORD = 2'd2
  } state_e;

  localparam logic [35:0] DEFAULT_WORKLOAD_VEC = 36'h0_8000_0000;
  localparam logic [35:0] DEFAULT_DRIVER_VEC   = 36'h0_1000_0000;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dse_out_fifo.sv
`default_nettype none
// ============================================================================
// Module  : dse_out_fifo
// Purpose : First-word-fall-through record buffer. The head entry is visible
//           on out_data whenever out_valid is high; a push becomes visible
//           the cycle after it is written.
// Ports   : clock, reset      - clock and synchronous active-high reset
//           push, push_data   - write request and data (ignored when full
//                               unless a pop happens in the same cycle)
//           pop               - consume head entry (ignored when empty)
//           out_valid,out_data- head entry
//           full, level       - occupancy status
// Rev     : 1.0  initial release
// ============================================================================
module dse_out_fifo #(
  parameter int WIDTH = 264,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign level     = count;

  assign do_pop  = pop && out_valid;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dse_stream_endpoint.sv
`default_nettype none
// ============================================================================
// Module  : dse_stream_endpoint
// Purpose : Watches DSE reset-vector pulses, runs an IDLE/ARMED/RECORD
//           controller and emits tagged records (EMULATE, DEG, DEGDONE,
//           FINISH) into a FWFT output buffer. Control records are never
//           lost; DEG records are dropped and counted when they cannot issue.
// Macro   : DSE_DROP_REPORT_EN - when defined, DEGDONE carries the drop
//           count in its low 32 bits and drop_count is live; otherwise both
//           read as zero.
// Ports   : clock, reset          - clock, synchronous active-high reset
//           dse_reset_valid/vector- reset-vector pulse and target address
//           deg_out_enable        - DEG sample strobe
//           deg_valids            - per-lane valid bits (popcount counted)
//           deg_out_data          - DEG payload
//           perf_out_data         - FINISH payload
//           out_valid/ready/data  - record stream {tag, payload}
//           fifo_level            - buffer occupancy
//           recording             - high while in RECORD
//           drop_count            - saturating count of dropped DEG records
// Rev     : 1.0  initial release
// ============================================================================
module dse_stream_endpoint
  import dse_pkg::*;
#(
  parameter int          NCH          = 4,
  parameter int          DEG_W        = 256,
  parameter int          PERF_W       = 192,
  parameter int          MAGIC_W      = 8,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          RECORD_THRES = 200,
  parameter logic [35:0] WORKLOAD_VEC = DEFAULT_WORKLOAD_VEC,
  parameter logic [35:0] DRIVER_VEC   = DEFAULT_DRIVER_VEC
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          dse_reset_valid,
  input  logic [35:0]                   dse_reset_vector,
  input  logic                          deg_out_enable,
  input  logic [NCH-1:0]                deg_valids,
  input  logic [DEG_W-1:0]              deg_out_data,
  input  logic [PERF_W-1:0]             perf_out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DEG_W+MAGIC_W-1:0]      out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          recording,
  output logic [31:0]                   drop_count
);

  localparam int REC_W = DEG_W + MAGIC_W;

  state_e            state;
  logic              last_rst;
  logic [31:0]       count;
  logic              pend_emu;
  logic              pend_done;
  logic              pend_fin;
  logic [PERF_W-1:0] perf_hold;

  logic              rise;
  logic              fall;
  logic              wl_rise;
  logic              drv_rise;
  logic              thres_hit;
  logic              rec_exit;
  logic              deg_event;
  logic              deg_push;
  logic              emu_req;
  logic              done_req;
  logic              fin_req;
  logic              any_pend;
  logic              fifo_full;
  logic              fifo_pop;
  logic              can_push;
  logic [31:0]       lane_sum;
  logic [DEG_W-1:0]  done_payload;
  logic [PERF_W-1:0] fin_perf;

  logic              push;
  tag_e              push_tag;
  logic [DEG_W-1:0]  push_payload;
  logic              take_emu;
  logic              take_done;
  logic              take_fin;

  assign rise      = dse_reset_valid && !last_rst;
  assign fall      = last_rst && !dse_reset_valid;
  assign wl_rise   = rise && (dse_reset_vector == WORKLOAD_VEC);
  assign drv_rise  = rise && (dse_reset_vector == DRIVER_VEC);
  assign thres_hit = (count >= 32'(RECORD_THRES));

  // The cycle in which the limit is already reached is the exit cycle: it
  // emits DEGDONE rather than one more DEG sample.
  assign deg_event = (state == ST_RECORD) && deg_out_enable && !thres_hit;
  assign rec_exit  = (state == ST_RECORD) && (thres_hit || drv_rise || wl_rise);

  assign emu_req   = wl_rise  || pend_emu;
  assign done_req  = rec_exit || pend_done;
  assign fin_req   = drv_rise || pend_fin;
  assign any_pend  = pend_emu || pend_done || pend_fin;

  assign fifo_pop  = out_valid && out_ready;
  assign can_push  = !fifo_full || fifo_pop;
  // DEG only issues when no control record is owed and EMULATE is not
  // claiming the slot this cycle.
  assign deg_push  = deg_event && can_push && !any_pend && !wl_rise;

  // A FINISH deferred by backpressure keeps the perf value seen at the rise.
  assign fin_perf  = drv_rise ? perf_out_data : perf_hold;

  assign recording = (state == ST_RECORD);

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      lane_sum = lane_sum + {31'b0, deg_valids[i]};
    end
  end

  always_comb begin
    push         = 1'b0;
    push_tag     = TAG_EMULATE;
    push_payload = '0;
    take_emu     = 1'b0;
    take_done    = 1'b0;
    take_fin     = 1'b0;
    if (can_push) begin
      if (emu_req) begin
        push     = 1'b1;
        take_emu = 1'b1;
      end else if (deg_push) begin
        push         = 1'b1;
        push_tag     = TAG_DEG;
        push_payload = deg_out_data;
      end else if (done_req) begin
        push         = 1'b1;
        take_done    = 1'b1;
        push_tag     = TAG_DEGDONE;
        push_payload = done_payload;
      end else if (fin_req) begin
        push         = 1'b1;
        take_fin     = 1'b1;
        push_tag     = TAG_FINISH;
        push_payload = DEG_W'(fin_perf);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      last_rst  <= 1'b0;
      count     <= '0;
      pend_emu  <= 1'b0;
      pend_done <= 1'b0;
      pend_fin  <= 1'b0;
      perf_hold <= '0;
    end else begin
      last_rst  <= dse_reset_valid;
      pend_emu  <= emu_req  && !take_emu;
      pend_done <= done_req && !take_done;
      pend_fin  <= fin_req  && !take_fin;
      if (drv_rise) perf_hold <= perf_out_data;

      if (wl_rise) begin
        count <= '0;
      end else if (deg_event) begin
        count <= sat_add32(count, lane_sum);
      end

      // A workload rise restarts the phase from any state.
      if (wl_rise) begin
        state <= ST_ARMED;
      end else begin
        case (state)
          ST_ARMED:  if (fall)     state <= ST_RECORD;
          ST_RECORD: if (rec_exit) state <= ST_IDLE;
          default:   ;
        endcase
      end
    end
  end

`ifdef DSE_DROP_REPORT_EN
  logic [31:0] drops;

  always_ff @(posedge clock) begin
    if (reset) begin
      drops <= '0;
    end else if (wl_rise) begin
      drops <= '0;
    end else if (deg_event && !deg_push && (drops != 32'hFFFF_FFFF)) begin
      drops <= drops + 32'd1;
    end
  end

  assign drop_count   = drops;
  assign done_payload = DEG_W'(drops);
`else
  assign drop_count   = '0;
  assign done_payload = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset && deg_out_enable && (deg_valids == '0)) begin
      $display("dse_stream_endpoint error: deg_out_enable with no valid lanes at %0t", $time);
    end
  end
`endif

  dse_out_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({MAGIC_W'(push_tag), push_payload}),
    .pop       (fifo_pop),
    .out_valid (out_valid),
    .out_data  (out_data),
    .full      (fifo_full),
    .level     (fifo_level)
  );

endmodule
`default_nettype wire

// File: tb/tb_dse_stream_endpoint.sv
`default_nettype none
// ============================================================================
// Module  : tb_dse_stream_endpoint
// Purpose : Self-checking bench for dse_stream_endpoint. A reference model
//           predicts every record into a scoreboard queue; a monitor pops
//           and compares on each output handshake. Directed scenarios cover
//           the threshold phase, driver exit, backpressure drops and reset,
//           followed by randomized traffic.
// Macro   : DSE_DROP_REPORT_EN (must match the RTL build)
// Rev     : 1.0  initial release
// ============================================================================
module tb_dse_stream_endpoint;

  localparam int NCH          = 4;
  localparam int DEG_W        = 256;
  localparam int PERF_W       = 192;
  localparam int MAGIC_W      = 8;
  localparam int FIFO_DEPTH   = 8;
  localparam int RECORD_THRES = 200;
  localparam int REC_W        = DEG_W + MAGIC_W;
  localparam logic [35:0] WL  = 36'h0_8000_0000;
  localparam logic [35:0] DRV = 36'h0_1000_0000;
`ifdef DSE_DROP_REPORT_EN
  localparam bit DROP_REP = 1'b1;
`else
  localparam bit DROP_REP = 1'b0;
`endif

  logic                        clock = 1'b0;
  logic                        reset = 1'b1;
  logic                        dse_reset_valid = 1'b0;
  logic [35:0]                 dse_reset_vector = '0;
  logic                        deg_out_enable = 1'b0;
  logic [NCH-1:0]              deg_valids = '0;
  logic [DEG_W-1:0]            deg_out_data = '0;
  logic [PERF_W-1:0]           perf_out_data = '0;
  logic                        out_valid;
  logic                        out_ready = 1'b0;
  logic [REC_W-1:0]            out_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        recording;
  logic [31:0]                 drop_count;

  always #5 clock = ~clock;

  dse_stream_endpoint dut (
    .clock            (clock),
    .reset            (reset),
    .dse_reset_valid  (dse_reset_valid),
    .dse_reset_vector (dse_reset_vector),
    .deg_out_enable   (deg_out_enable),
    .deg_valids       (deg_valids),
    .deg_out_data     (deg_out_data),
    .perf_out_data    (perf_out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .fifo_level       (fifo_level),
    .recording        (recording),
    .drop_count       (drop_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: phase (0 idle, 1 armed, 2 record), owed control
  // records, lane total, drop total and how many records sit in the buffer.
  int                m_state;
  bit                m_last;
  longint            m_count;
  logic [31:0]       m_drops;
  bit                m_pe, m_pd, m_pf;
  logic [PERF_W-1:0] m_perf;
  int                m_level;
  logic [REC_W-1:0]  exp_q[$];

  int               tag_seen[5];
  int               done_cyc, fin_cyc;
  logic [31:0]      done_low;
  logic [REC_W-1:0] mon_exp;
  int               mon_tag;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every handshake must match the oldest prediction.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL record: got tag %0d with nothing expected (cycle %0d)",
                 out_data[REC_W-1 -: MAGIC_W], cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          n_bad++;
          $display("FAIL record: got tag %0d payload %0h, expected tag %0d payload %0h (cycle %0d)",
                   out_data[REC_W-1 -: MAGIC_W], out_data[DEG_W-1:0],
                   mon_exp[REC_W-1 -: MAGIC_W], mon_exp[DEG_W-1:0], cyc);
        end
      end
      mon_tag = int'(out_data[REC_W-1 -: MAGIC_W]);
      if (mon_tag >= 1 && mon_tag <= 4) tag_seen[mon_tag]++;
      if (mon_tag == 3) begin
        done_cyc = cyc;
        done_low = out_data[31:0];
      end
      if (mon_tag == 4) fin_cyc = cyc;
    end
  end

  function automatic logic [REC_W-1:0] mk(input int tag, input logic [DEG_W-1:0] pl);
    return {MAGIC_W'(tag), pl};
  endfunction

  function automatic logic [DEG_W-1:0] rand_deg();
    logic [DEG_W-1:0] r;
    for (int i = 0; i < DEG_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [PERF_W-1:0] rand_perf();
    logic [PERF_W-1:0] r;
    for (int i = 0; i < PERF_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_last = 0; m_count = 0; m_drops = '0;
    m_pe = 0; m_pd = 0; m_pf = 0; m_perf = '0; m_level = 0;
    exp_q.delete();
  endtask

  // One clock of behaviour, from the inputs being driven this cycle.
  task automatic model_step();
    bit rise, fall, wl, drv, deg_ev, ext, pop, room, e, d, f, deg_taken;
    int pushed;
    rise   = dse_reset_valid && !m_last;
    fall   = m_last && !dse_reset_valid;
    wl     = rise && (dse_reset_vector == WL);
    drv    = rise && (dse_reset_vector == DRV);
    deg_ev = (m_state == 2) && deg_out_enable && (m_count < RECORD_THRES);
    ext    = (m_state == 2) && ((m_count >= RECORD_THRES) || drv || wl);
    pop    = (m_level > 0) && out_ready;
    room   = (m_level < FIFO_DEPTH) || pop;
    e = wl || m_pe;  d = ext || m_pd;  f = drv || m_pf;
    if (drv) m_perf = perf_out_data;
    pushed = 0;
    deg_taken = 0;
    if (room) begin
      if (e) begin
        exp_q.push_back(mk(1, '0)); e = 0; pushed = 1;
      end else if (deg_ev && !(m_pe || m_pd || m_pf)) begin
        exp_q.push_back(mk(2, deg_out_data)); deg_taken = 1; pushed = 1;
      end else if (d) begin
        exp_q.push_back(mk(3, DROP_REP ? DEG_W'(m_drops) : '0)); d = 0; pushed = 1;
      end else if (f) begin
        exp_q.push_back(mk(4, DEG_W'(m_perf))); f = 0; pushed = 1;
      end
    end
    m_pe = e; m_pd = d; m_pf = f;
    if (wl) m_drops = '0;
    else if (deg_ev && !deg_taken && m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
    if (wl) m_count = 0;
    else if (deg_ev) begin
      m_count = m_count + $countones(deg_valids);
      if (m_count > 64'hFFFF_FFFF) m_count = 64'hFFFF_FFFF;
    end
    if (wl) m_state = 1;
    else if (m_state == 1 && fall) m_state = 2;
    else if (m_state == 2 && ext) m_state = 0;
    m_last  = dse_reset_valid;
    m_level = m_level + pushed - (pop ? 1 : 0);
  endtask

  task automatic check_state();
    chk("out_valid",  out_valid,  m_level > 0);
    chk("fifo_level", fifo_level, m_level);
    chk("recording",  recording,  m_state == 2);
    chk("drop_count", drop_count, DROP_REP ? m_drops : 32'd0);
  endtask

  task automatic cycle(input bit rv, input logic [35:0] vec, input bit en,
                       input logic [NCH-1:0] val, input bit rdy, input logic [PERF_W-1:0] perf);
    dse_reset_valid  = rv;
    dse_reset_vector = vec;
    deg_out_enable   = en;
    deg_valids       = val;
    out_ready        = rdy;
    deg_out_data     = rand_deg();
    perf_out_data    = perf;
    model_step();
    @(posedge clock);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dse_reset_valid = 1'b0;
    deg_out_enable  = 1'b0;
    out_ready       = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    chk("reset out_valid",  out_valid,  1'b0);
    chk("reset fifo_level", fifo_level, 0);
    chk("reset recording",  recording,  1'b0);
    chk("reset drop_count", drop_count, 0);
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 5; i++) tag_seen[i] = 0;
    done_cyc = -1; fin_cyc = -1; done_low = '1;
  endtask

  // Workload pulse of three cycles followed by the falling edge cycle.
  task automatic enter_record();
    repeat (3) cycle(1, WL, 0, 4'h1, 1, rand_perf());
    cycle(0, WL, 0, 4'h1, 1, rand_perf());
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(0, '0, 0, 4'h1, 1, rand_perf());
  endtask

  initial begin
    logic [35:0] vec;
    bit rv;
    int r;
    model_reset();
    clear_obs();
    do_reset();

    // Full phase ended by the lane threshold: 50 samples of 4 lanes.
    clear_obs();
    repeat (3) cycle(1, WL, 0, 4'h1, 1, rand_perf());
    repeat (60) cycle(0, WL, 1, 4'hF, 1, rand_perf());
    drain(5);
    chk("thres emulate count", tag_seen[1], 1);
    chk("thres deg count",     tag_seen[2], 50);
    chk("thres degdone count", tag_seen[3], 1);
    chk("thres recording low", recording, 1'b0);

    // Driver exit: DEGDONE and FINISH on consecutive cycles.
    clear_obs();
    enter_record();
    repeat (3) cycle(0, '0, 0, 4'h1, 1, rand_perf());
    cycle(1, DRV, 0, 4'h1, 1, 192'hABC);
    drain(5);
    chk("driver finish count", tag_seen[4], 1);
    chk("driver finish follows degdone", fin_cyc - done_cyc, 1);

    // Backpressure: 12 samples into an 8-deep buffer drop 4.
    clear_obs();
    enter_record();
    repeat (12) cycle(0, '0, 1, 4'h1, 0, rand_perf());
    chk("bp fifo_level", fifo_level, 8);
    chk("bp drop_count", drop_count, DROP_REP ? 4 : 0);
    cycle(1, DRV, 0, 4'h1, 1, rand_perf());
    drain(15);
    chk("bp deg count", tag_seen[2], 8);
    chk("bp degdone low word", done_low, DROP_REP ? 32'd4 : 32'd0);

    // Driver rise alongside a sample while full: sample dropped, FINISH owed.
    clear_obs();
    enter_record();
    repeat (8) cycle(0, '0, 1, 4'h3, 0, rand_perf());
    cycle(1, DRV, 1, 4'h3, 0, 192'h5A5);
    chk("full drop_count", drop_count, DROP_REP ? 1 : 0);
    repeat (2) cycle(1, DRV, 0, 4'h1, 0, rand_perf());
    drain(15);
    chk("full deg count", tag_seen[2], 8);
    chk("full finish count", tag_seen[4], 1);
    chk("full finish after degdone", fin_cyc > done_cyc, 1'b1);

    // Reset with five records buffered.
    enter_record();
    repeat (5) cycle(0, '0, 1, 4'hF, 0, rand_perf());
    chk("pre-reset fifo_level", fifo_level, 5);
    do_reset();
    drain(3);

    // Randomized traffic.
    rv = 0;
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) rv = !rv;
      r = $urandom_range(0, 9);
      vec = (r < 5) ? WL : (r < 8) ? DRV : {4'h0, $urandom};
      cycle(rv, vec, $urandom_range(0, 3) != 0, 4'($urandom_range(1, 15)),
            $urandom_range(0, 9) < 7, rand_perf());
    end
    drain(30);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dse_stream_endpoint.md
DSE_STREAM_ENDPOINT -- requirements
Module: dse_stream_endpoint

Interface
REQ-001 SHALL have parameter NCH, default 4: number of DEG valid lanes.
REQ-002 SHALL have parameter DEG_W, default 256: DEG payload width.
REQ-003 SHALL have parameter PERF_W, default 192: perf payload width, PERF_W <= DEG_W.
REQ-004 SHALL have parameter MAGIC_W, default 8: record tag width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8: output buffer depth, power of two, >= 2.
REQ-006 SHALL have parameter RECORD_THRES, default 200: lane-record limit per phase.
REQ-007 SHALL have parameters WORKLOAD_VEC, default 36'h80000000, and DRIVER_VEC, default 36'h10000000: reset-vector targets.
REQ-008 SHALL have ports: clock in 1, clock; reset in 1, synchronous, active-high.
REQ-009 SHALL have ports: dse_reset_valid in 1; dse_reset_vector in 36; deg_out_enable in 1; deg_valids in NCH; deg_out_data in DEG_W; perf_out_data in PERF_W.
REQ-010 SHALL have ports: out_valid out 1; out_ready in 1; out_data out DEG_W+MAGIC_W, {tag, payload}; fifo_level out $clog2(FIFO_DEPTH)+1; recording out 1; drop_count out 32.

Function
REQ-011 SHALL detect rise = dse_reset_valid && !last_rst and fall = last_rst && !dse_reset_valid, where last_rst is registered dse_reset_valid.
REQ-012 SHALL implement FSM IDLE, ARMED, RECORD.
- IDLE -> ARMED on rise with vector == WORKLOAD_VEC.
- ARMED -> RECORD one cycle after fall.
- RECORD -> IDLE on count >= RECORD_THRES or on rise with vector == DRIVER_VEC.
REQ-013 SHALL generate tags 1 EMULATE, 2 DEG, 3 DEGDONE, 4 FINISH.
- EMULATE: on workload rise (any state), zero payload; also clears count and drop_count.
- DEG: each RECORD cycle with deg_out_enable, payload deg_out_data.
- DEGDONE: on RECORD exit, zero payload.
- FINISH: on driver rise, payload zero-extended perf_out_data.
REQ-014 SHALL add popcount(deg_valids) to a 32-bit count per DEG event; count saturates.
REQ-015 SHALL push at most one record per cycle, priority EMULATE > DEG > DEGDONE > FINISH; losing control records become pending flags and issue in the first free cycle, in the same order.
REQ-016 SHALL never drop control records; while a control record is pending or the FIFO is full, a DEG event is dropped and drop_count increments, saturating at all-ones.
REQ-017 SHALL buffer records in a first-word-fall-through FIFO; out_valid = not empty; a pop occurs on out_valid && out_ready; push and pop in the same cycle when full is legal.
REQ-018 SHALL give push-to-out_valid latency of 1 cycle when the FIFO is empty.
REQ-019 SHALL treat a workload rise while in RECORD as DEGDONE (pending), then EMULATE, with the FSM entering ARMED.
REQ-020 SHALL, in simulation only, $display an error when deg_out_enable is high with deg_valids == 0; the count is unchanged.
REQ-021 SHALL assert recording only in RECORD.

Reset
REQ-022 SHALL, on reset, set state IDLE, last_rst 0, count 0, drop_count 0, pending flags 0, FIFO empty, out_valid 0, fifo_level 0, recording 0.
REQ-023 SHALL discard FIFO contents and pending records on reset mid-operation.

Configuration
REQ-024 SHALL support macro DSE_DROP_REPORT_EN.
- Defined: DEGDONE payload low 32 bits = drop_count at emission; drop_count port live.
- Undefined: DEGDONE payload zero; drop_count port tied 0; drops still occur.

Structure
REQ-025 SHALL place the tag constants (enum), the FSM state typedef, and the default vectors in package dse_pkg.
REQ-026 SHALL instantiate one sub-module dse_out_fifo (parametrised width and depth, FWFT, level output).

Verification
REQ-027 SHALL cover: workload rise for 3 cycles, then deg_out_enable 60 cycles with deg_valids=4'b1111, out_ready=1 -> tags 1, then 50x tag 2, then tag 3; recording falls once count reaches 200.
REQ-028 SHALL cover: in RECORD, driver rise with perf=0xABC -> tag 3 then tag 4, payload 0xABC, on consecutive cycles.
REQ-029 SHALL cover: out_ready=0, 12 DEG events, FIFO_DEPTH=8 -> fifo_level=8, drop_count=4; with DSE_DROP_REPORT_EN, DEGDONE low word = 4.
REQ-030 SHALL cover: driver rise same cycle as DEG event with a full FIFO -> DEG dropped, FINISH pending, FINISH emitted after first pop.
REQ-031 SHALL cover: reset asserted with 5 entries buffered -> next cycle out_valid=0, fifo_level=0, state IDLE.
